ext_bus_responder: RTL and testbench
====================================

EXT_BUS_RESPONDER -- requirements
Module: ext_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of the number of 16-bit halfwords in the internal memory.
REQ-002 SHALL have port clk  in  1  single clock; all inputs sampled on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port din  in  16  multiplexed bus value as seen by the responder.
REQ-005 SHALL have port dout  out  16  read data driven onto the bus.
REQ-006 SHALL have port isout  out  1  bus drive enable; the top tristates the bus when low.
REQ-007 SHALL have ports ale0 and ale1  in  1 each  address latch enables for address[15:0] and address[31:16].
REQ-008 SHALL have ports oe_n, we_n, bhe_n  in  1 each  active-low output enable, write enable and byte-high enable.
REQ-009 SHALL have ports addr  out  32  current latched address, and err  out  1  sticky protocol or range error.

Function
REQ-010 SHALL treat every input as synchronous to clk; no internal synchronisers.
REQ-011 SHALL load addr[15:0] from din in each cycle ale0 is sampled high, and addr[31:16] from din in each cycle ale1 is sampled high; the value held at the ale falling edge is final.
REQ-012 SHALL implement FSM IDLE, RD, WR: IDLE->RD on oe_n low with we_n high; IDLE->WR on we_n low with oe_n high; RD->IDLE on oe_n high; WR->IDLE on we_n high.
REQ-013 SHALL in RD set isout=1 and dout=mem[addr[ADDR_W:1]] one cycle after oe_n is first sampled low, and clear isout one cycle after oe_n is sampled high.
REQ-014 SHALL in WR capture din every cycle, and commit the last captured value to memory in the cycle we_n is sampled high (strobe end).
REQ-015 SHALL use byte enables: low byte written when addr[0]=0; high byte written when bhe_n was low during the strobe; unselected bytes unchanged.
REQ-016 SHALL, at the end of every completed RD or WR strobe, increment addr by 2 (32-bit wrap), so one address phase followed by two strobes moves one 32-bit word.
REQ-017 SHALL, if oe_n and we_n are sampled low together in IDLE, stay in IDLE, perform no access and set err.
REQ-018 SHALL, if ale0 or ale1 is sampled high while in RD or WR, ignore the address load, set err, and complete the strobe at the unchanged address.
REQ-019 SHALL treat addr[31:ADDR_W+1] nonzero as out of range: writes discarded, reads return 16'hFFFF, err set; the address still increments.
REQ-020 SHALL clear isout in the same cycle the FSM enters WR, so isout and a write strobe never overlap.
REQ-021 SHALL keep err set until reset.

Reset
REQ-022 SHALL on reset set FSM=IDLE, isout=0, dout=0, addr=0, err=0; memory contents are not cleared.
REQ-023 SHALL on reset mid-strobe abandon the access: no memory write, isout low next cycle, no address increment.

Structure
REQ-024 SHALL take FSM state encoding and the out-of-range read value 16'hFFFF from the shared bus package, which the initiator side also imports.
REQ-025 SHALL place the halfword array with byte-write enables in one sub-module, resp_mem, with one registered read port and one write port.

Verification
REQ-026 Sequence ale0 with din=0x0010, ale1 with din=0x0000, WE strobe din=0xAAAA (bhe_n=0), WE strobe din=0x5555 -> mem[8]=0xAAAA, mem[9]=0x5555, addr=0x14, err=0.
REQ-027 Re-latch addr 0x10, two OE strobes -> dout 0xAAAA then 0x5555, isout high only inside each strobe (+1 cycle lag), addr=0x14.
REQ-028 Addr 0x11, bhe_n=0, WE din=0x1234 on mem=0xAAAA -> mem[8]=0x12AA; with bhe_n=1 -> mem[8] unchanged.
REQ-029 oe_n and we_n low together -> no state change, memory untouched, err=1 until reset.
REQ-030 Addr 0x0001_0000, OE strobe -> dout=0xFFFF, err=1; WE strobe there -> no memory change.
REQ-031 Reset asserted during a WE strobe -> target halfword unchanged, addr=0, isout=0, FSM IDLE.

Source files
------------

// File: rtl/ext_bus_responder_pkg.sv
// Shared definitions for the multiplexed external bus.
// Both the responder and the initiator side import this package so that the
// strobe-state encoding and the out-of-range read pattern stay in one place.
//   bus_state_e    : responder strobe state (idle / read strobe / write strobe)
//   OOR_READ_DATA  : value returned for reads outside the implemented memory
//   next_halfword  : address advance applied at the end of every strobe
package ext_bus_responder_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_RD   = 2'd1,
    BUS_WR   = 2'd2
  } bus_state_e;

  localparam logic [15:0] OOR_READ_DATA = 16'hFFFF;

  // One strobe moves one halfword; the 32-bit address wraps naturally.
  function automatic logic [31:0] next_halfword(input logic [31:0] a);
    return a + 32'd2;
  endfunction

endpackage

// File: rtl/ext_bus_responder_mem.sv
// Halfword memory for the external bus responder.
// One registered read port and one write port with per-byte enables.
// Contents are never reset.
//   clk      : clock
//   rd_en    : load rd_data from mem[rd_idx] on the next rising edge
//   rd_idx   : halfword index for the read port
//   rd_data  : registered read data (holds while rd_en is low)
//   wr_en    : commit wr_data to mem[wr_idx] on the next rising edge
//   wr_be    : byte enables, [0] = bits 7:0, [1] = bits 15:8
//   wr_idx   : halfword index for the write port
//   wr_data  : write data
module resp_mem
  import ext_bus_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [15:0]       rd_data,
  input  logic              wr_en,
  input  logic [1:0]        wr_be,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [15:0]       wr_data
);

  logic [15:0] mem_q [2**ADDR_W];
  logic [15:0] rd_data_q;
  logic [15:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) begin
      if (wr_be[0]) mem_q[wr_idx][7:0]  <= wr_data[7:0];
      if (wr_be[1]) mem_q[wr_idx][15:8] <= wr_data[15:8];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ext_bus_responder.sv
// Responder for a 16-bit multiplexed address/data external bus.
// A 32-bit address is latched in two halves (ale0 / ale1); each following
// read (oe_n) or write (we_n) strobe transfers one halfword of the internal
// memory and advances the address by 2. Protocol violations and accesses
// outside the implemented memory raise a sticky err flag.
//   clk    : clock, every input is sampled on its rising edge
//   reset  : synchronous active-high reset
//   din    : bus value seen by the responder (address or write data)
//   dout   : read data driven onto the bus
//   isout  : bus drive enable (top level tristates the bus when low)
//   ale0   : latch address[15:0] from din
//   ale1   : latch address[31:16] from din
//   oe_n   : active-low read strobe
//   we_n   : active-low write strobe
//   bhe_n  : active-low byte-high enable for writes
//   addr   : current latched address
//   err    : sticky protocol / range error
module ext_bus_responder
  import ext_bus_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        isout,
  input  logic        ale0,
  input  logic        ale1,
  input  logic        oe_n,
  input  logic        we_n,
  input  logic        bhe_n,
  output logic [31:0] addr,
  output logic        err
);

  bus_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        isout_q, isout_d;
  logic        err_q, err_d;
  logic [15:0] wdata_q, wdata_d;
  logic        bhe_seen_q, bhe_seen_d;

  logic        in_range;
  logic        ale_any;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [15:0] mem_rd_data;

  // Anything above the implemented halfword index is outside the memory.
  assign in_range = (addr_q[31:ADDR_W+1] == '0);
  assign ale_any  = ale0 | ale1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    isout_d    = 1'b0;
    err_d      = err_q;
    wdata_d    = wdata_q;
    bhe_seen_d = bhe_seen_q;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;

    unique case (state_q)
      BUS_IDLE: begin
        if (ale0) addr_d[15:0]  = din;
        if (ale1) addr_d[31:16] = din;
        if (!oe_n && !we_n) begin
          // Conflicting strobes: no access at all, just flag it.
          err_d = 1'b1;
        end else if (!oe_n) begin
          state_d   = BUS_RD;
          mem_rd_en = 1'b1;
        end else if (!we_n) begin
          state_d    = BUS_WR;
          wdata_d    = din;
          bhe_seen_d = !bhe_n;
        end
      end

      BUS_RD: begin
        // Drive stays on for the cycle after oe_n rises, giving the
        // one-cycle lag on both edges of the strobe.
        isout_d = 1'b1;
        dout_d  = in_range ? mem_rd_data : OOR_READ_DATA;
        if (!in_range) err_d = 1'b1;
        if (ale_any)   err_d = 1'b1;
        if (oe_n) begin
          state_d = BUS_IDLE;
          addr_d  = next_halfword(addr_q);
        end else begin
          mem_rd_en = 1'b1;
        end
      end

      BUS_WR: begin
        if (!in_range) err_d = 1'b1;
        if (ale_any)   err_d = 1'b1;
        if (we_n) begin
          // Strobe end: commit the last captured data.
          mem_wr_en = in_range;
          state_d   = BUS_IDLE;
          addr_d    = next_halfword(addr_q);
        end else begin
          wdata_d    = din;
          bhe_seen_d = bhe_seen_q | !bhe_n;
        end
      end

      default: begin
        state_d = BUS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      isout_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      isout_q <= isout_d;
      err_q   <= err_d;
    end
  end

  // Write capture needs no reset: it is only consumed after a fresh strobe
  // has reloaded it.
  always_ff @(posedge clk) begin
    wdata_q    <= wdata_d;
    bhe_seen_q <= bhe_seen_d;
  end

  // Reset mid-strobe must abandon the write, so the commit is gated here.
  resp_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rd_en   (mem_rd_en),
    .rd_idx  (addr_q[ADDR_W:1]),
    .rd_data (mem_rd_data),
    .wr_en   (mem_wr_en & ~reset),
    .wr_be   ({bhe_seen_q, ~addr_q[0]}),
    .wr_idx  (addr_q[ADDR_W:1]),
    .wr_data (wdata_q)
  );

  assign dout  = dout_q;
  assign isout = isout_q;
  assign addr  = addr_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ext_bus_responder.sv
module tb_ext_bus_responder;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic [15:0] dout;
  logic        isout;
  logic        ale0;
  logic        ale1;
  logic        oe_n;
  logic        we_n;
  logic        bhe_n;
  logic [31:0] addr;
  logic        err;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  ext_bus_responder #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout),
    .isout (isout),
    .ale0  (ale0),
    .ale1  (ale1),
    .oe_n  (oe_n),
    .we_n  (we_n),
    .bhe_n (bhe_n),
    .addr  (addr),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic addr_phase(input logic [15:0] lo, input logic [15:0] hi);
    din  = lo;
    ale0 = 1'b1;
    tick();
    ale0 = 1'b0;
    din  = hi;
    ale1 = 1'b1;
    tick();
    ale1 = 1'b0;
    din  = 16'h0;
    chk("addr_latch", addr, {hi, lo});
  endtask

  task automatic wr_strobe(input logic [15:0] data, input logic bhe);
    din   = data;
    bhe_n = bhe;
    we_n  = 1'b0;
    tick();
    chk("wr_isout_off", {31'b0, isout}, 32'd0);
    tick();
    we_n = 1'b1;
    tick();
    bhe_n = 1'b1;
    din   = 16'h0;
  endtask

  task automatic rd_strobe(input logic [15:0] expv);
    logic [15:0] e;
    exp_q.push_back(expv);
    chk("rd_isout_pre", {31'b0, isout}, 32'd0);
    oe_n = 1'b0;
    tick();
    chk("rd_isout_lag_on", {31'b0, isout}, 32'd0);
    tick();
    chk("rd_isout_on", {31'b0, isout}, 32'd1);
    e = exp_q.pop_front();
    chk("rd_dout", {16'b0, dout}, {16'b0, e});
    oe_n = 1'b1;
    tick();
    chk("rd_isout_lag_off", {31'b0, isout}, 32'd1);
    tick();
    chk("rd_isout_off", {31'b0, isout}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    din   = 16'h0;
    ale0  = 1'b0;
    ale1  = 1'b0;
    oe_n  = 1'b1;
    we_n  = 1'b1;
    bhe_n = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_addr", addr, 32'd0);
    chk("reset_isout", {31'b0, isout}, 32'd0);
    chk("reset_dout", {16'b0, dout}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);

    // Two-halfword write burst
    addr_phase(16'h0010, 16'h0000);
    wr_strobe(16'hAAAA, 1'b0);
    wr_strobe(16'h5555, 1'b0);
    chk("wr_burst_addr", addr, 32'h14);
    chk("wr_burst_err", {31'b0, err}, 32'd0);

    // Read back burst
    addr_phase(16'h0010, 16'h0000);
    rd_strobe(16'hAAAA);
    rd_strobe(16'h5555);
    chk("rd_burst_addr", addr, 32'h14);
    chk("rd_burst_err", {31'b0, err}, 32'd0);

    // Odd address: high byte only, then nothing with bhe_n high
    addr_phase(16'h0011, 16'h0000);
    wr_strobe(16'h1234, 1'b0);
    chk("odd_wr_addr", addr, 32'h13);
    addr_phase(16'h0011, 16'h0000);
    wr_strobe(16'h5678, 1'b1);
    addr_phase(16'h0010, 16'h0000);
    rd_strobe(16'h12AA);
    rd_strobe(16'h5555);
    addr_phase(16'h0000, 16'h0000);
    wr_strobe(16'h0F0F, 1'b0);
    chk("byte_err", {31'b0, err}, 32'd0);

    // Conflicting strobes
    addr_phase(16'h0010, 16'h0000);
    oe_n = 1'b0;
    we_n = 1'b0;
    din  = 16'hBAD0;
    tick();
    tick();
    chk("conflict_isout", {31'b0, isout}, 32'd0);
    chk("conflict_addr", addr, 32'h10);
    chk("conflict_err", {31'b0, err}, 32'd1);
    oe_n = 1'b1;
    we_n = 1'b1;
    tick();
    rd_strobe(16'h12AA);
    chk("conflict_err_sticky", {31'b0, err}, 32'd1);
    do_reset();
    chk("conflict_err_cleared", {31'b0, err}, 32'd0);

    // Out-of-range read and write
    addr_phase(16'h0000, 16'h0001);
    rd_strobe(16'hFFFF);
    chk("oor_rd_err", {31'b0, err}, 32'd1);
    chk("oor_rd_addr", addr, 32'h0001_0002);
    addr_phase(16'h0000, 16'h0001);
    wr_strobe(16'hBEEF, 1'b0);
    chk("oor_wr_addr", addr, 32'h0001_0002);
    do_reset();
    rd_strobe(16'h0F0F);

    // Address latch during a read strobe is ignored
    addr_phase(16'h0012, 16'h0000);
    exp_q.push_back(16'h5555);
    oe_n = 1'b0;
    tick();
    din  = 16'h0040;
    ale0 = 1'b1;
    tick();
    ale0 = 1'b0;
    din  = 16'h0;
    chk("ale_in_rd_dout", {16'b0, dout}, {16'b0, exp_q.pop_front()});
    chk("ale_in_rd_addr", addr, 32'h12);
    oe_n = 1'b1;
    tick();
    tick();
    chk("ale_in_rd_addr_inc", addr, 32'h14);
    chk("ale_in_rd_err", {31'b0, err}, 32'd1);
    do_reset();

    // Reset during a write strobe
    addr_phase(16'h0010, 16'h0000);
    din  = 16'hDEAD;
    bhe_n = 1'b0;
    we_n = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_wr_isout", {31'b0, isout}, 32'd0);
    chk("rst_wr_addr", addr, 32'd0);
    reset = 1'b0;
    we_n  = 1'b1;
    bhe_n = 1'b1;
    din   = 16'h0;
    tick();
    chk("rst_wr_addr_hold", addr, 32'd0);
    chk("rst_wr_err", {31'b0, err}, 32'd0);
    addr_phase(16'h0010, 16'h0000);
    rd_strobe(16'h12AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
